tile_scheduler: RTL and testbench
=================================

Name: tile_scheduler

Overview:
- Top-level sequencer for one convolution/GEMM layer on the systolic array.
- Walks the layer as N output-channel tiles. Each N tile is made of K input-channel (reduction) tiles.
- Issues one start to the array controller per (n,k) tile and tells the accumulator bank whether to overwrite or accumulate.
- After the last K tile of each N tile, triggers the output writeback engine and waits for it to finish. Sits between the host config interface and the array controller/writeback engine.

Parameters:
- CNT_W, 8, width of tile counts and tile indices.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cfg_valid  in  1  layer config valid
- cfg_k_tiles  in  CNT_W  number of K tiles per N tile (0 treated as 1)
- cfg_n_tiles  in  CNT_W  number of N tiles (0 treated as 1)
- cfg_ready  out  1  scheduler idle, config accepted this cycle if cfg_valid
- ctrl_start  out  1  one-cycle start pulse to array controller
- ctrl_ready  in  1  array controller idle/ready
- acc_clr  out  1  qualifies ctrl_start: 1 = overwrite accumulators (first K tile), 0 = accumulate
- wb_start  out  1  one-cycle pulse to writeback engine
- wb_done  in  1  one-cycle pulse, writeback finished
- k_idx  out  CNT_W  current K tile index
- n_idx  out  CNT_W  current N tile index
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse, layer complete

Behaviour:
- Interface: one clock `clk`, synchronous active-high reset `rst`. All outputs are registered.
- Reset values: state=IDLE, cfg_ready=1, busy=0, ctrl_start=0, acc_clr=0, wb_start=0, done=0, k_idx=0, n_idx=0.
- Reset mid-operation: returns to IDLE next cycle. All in-flight counts are discarded. No pulse outputs are asserted in that cycle.
- Latched config:
  - k_last = max(cfg_k_tiles,1)-1 and n_last = max(cfg_n_tiles,1)-1, taken on acceptance.
  - cfg inputs are ignored outside IDLE.

FSM states: IDLE, ISSUE, ACK, RUN, WB, WB_WAIT, FIN.
- IDLE:
  - cfg_ready=1.
  - On cfg_valid: latch counts, k_idx=0, n_idx=0, go to ISSUE.
- ISSUE:
  - Waits for ctrl_ready=1.
  - In the cycle ctrl_ready=1 is seen: register ctrl_start=1 and acc_clr=(k_idx==0) for exactly one cycle, then go to ACK.
- ACK:
  - Waits for ctrl_ready=0, i.e. the controller has accepted the start.
  - Then go to RUN.
  - ctrl_start is not reissued while waiting.
- RUN:
  - Waits for ctrl_ready=1 (tile finished).
  - If k_idx==k_last, go to WB.
  - Else k_idx++, go to ISSUE.
- WB:
  - wb_start=1 for one cycle, then go to WB_WAIT.
- WB_WAIT:
  - On wb_done:
    - If n_idx==n_last, go to FIN.
    - Else n_idx++, k_idx=0, go to ISSUE.
- FIN:
  - done=1 for one cycle, then go to IDLE. k_idx/n_idx hold their last values until the next accept.
- wb_done outside WB_WAIT is ignored.
- ctrl_ready toggles outside ISSUE/ACK/RUN are ignored.
- acc_clr is 0 whenever ctrl_start=0.
- Latency:
  - Accept to first ctrl_start: 2 cycles, if ctrl_ready is already 1.
  - Tile end (ctrl_ready rise seen in RUN) to next ctrl_start: 2 cycles.
- Indices never wrap. Counters reach at most k_last/n_last. With CNT_W=8, a count of 256 tiles is not expressible and 0 means 1.

Test Plan:
- Reset, then cfg k=1,n=1; controller model drops ready 1 cycle after start, raises it 5 cycles later; wb_done 3 cycles after wb_start -> exactly 1 ctrl_start with acc_clr=1, 1 wb_start, 1 done; cfg_ready back to 1.
- cfg k=3,n=2 -> 6 ctrl_starts with acc_clr pattern 1,0,0,1,0,0; (k_idx,n_idx) at each start = (0,0),(1,0),(2,0),(0,1),(1,1),(2,1); wb_start after the 3rd and 6th tiles; done once.
- cfg k=0,n=0 -> behaves as k=1,n=1: one start, one writeback, one done.
- ctrl_ready held 0 for 10 cycles in ISSUE, and held 1 for 4 cycles after start (slow ack) -> no ctrl_start until ready; only one ctrl_start per tile; no advance until ready drops then rises.
- cfg_valid pulsed with k=5 while busy, plus a spurious wb_done during RUN -> both ignored; layer completes with the original counts.
- rst asserted in WB_WAIT of a k=2,n=3 layer -> next cycle IDLE with all outputs at reset values; a new cfg k=1,n=1 runs cleanly to done.

Source files
------------

// File: rtl/tile_scheduler.sv
// rtl/tile_scheduler.sv - layer tile sequencer for the systolic array
//
// Walks a layer as n_tiles output-channel tiles, each made of k_tiles
// reduction tiles. Issues one ctrl_start per (n,k) tile, flags the first K
// tile with acc_clr, and runs a writeback after the last K tile of each N tile.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   cfg_valid/cfg_ready      layer config handshake (accepted only when idle)
//   cfg_k_tiles/cfg_n_tiles  tile counts, 0 is treated as 1
//   ctrl_start, acc_clr      start pulse to array controller, overwrite flag
//   ctrl_ready               array controller idle/ready
//   wb_start, wb_done        writeback engine start pulse / finished pulse
//   k_idx, n_idx             current tile indices
//   busy, done               not idle / layer complete pulse
module tile_scheduler #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_k_tiles,
  input  logic [CNT_W-1:0] cfg_n_tiles,
  output logic             cfg_ready,
  output logic             ctrl_start,
  input  logic             ctrl_ready,
  output logic             acc_clr,
  output logic             wb_start,
  input  logic             wb_done,
  output logic [CNT_W-1:0] k_idx,
  output logic [CNT_W-1:0] n_idx,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_ACK, S_RUN, S_WB, S_WB_WAIT, S_FIN
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] k_last, n_last, k_last_n, n_last_n;
  logic [CNT_W-1:0] k_n, n_n;
  logic             ctrl_start_n, acc_clr_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      k_last     <= '0;
      n_last     <= '0;
      k_idx      <= '0;
      n_idx      <= '0;
      ctrl_start <= 1'b0;
      acc_clr    <= 1'b0;
      wb_start   <= 1'b0;
      done       <= 1'b0;
      cfg_ready  <= 1'b1;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      k_last     <= k_last_n;
      n_last     <= n_last_n;
      k_idx      <= k_n;
      n_idx      <= n_n;
      ctrl_start <= ctrl_start_n;
      acc_clr    <= acc_clr_n;
      // Single-cycle states, so these are naturally one-cycle pulses.
      wb_start   <= (state_n == S_WB);
      done       <= (state_n == S_FIN);
      cfg_ready  <= (state_n == S_IDLE);
      busy       <= (state_n != S_IDLE);
    end
  end

  always_comb begin
    state_n      = state;
    k_last_n     = k_last;
    n_last_n     = n_last;
    k_n          = k_idx;
    n_n          = n_idx;
    ctrl_start_n = 1'b0;
    acc_clr_n    = 1'b0;
    case (state)
      S_IDLE: begin
        if (cfg_valid) begin
          // Stored as last index so a count of 0 behaves like 1.
          k_last_n = (cfg_k_tiles == '0) ? '0 : cfg_k_tiles - CNT_W'(1);
          n_last_n = (cfg_n_tiles == '0) ? '0 : cfg_n_tiles - CNT_W'(1);
          k_n      = '0;
          n_n      = '0;
          state_n  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (ctrl_ready) begin
          ctrl_start_n = 1'b1;
          acc_clr_n    = (k_idx == '0);
          state_n      = S_ACK;
        end
      end
      S_ACK: begin
        // Controller acknowledges a start by dropping ready.
        if (!ctrl_ready) state_n = S_RUN;
      end
      S_RUN: begin
        if (ctrl_ready) begin
          if (k_idx == k_last) begin
            state_n = S_WB;
          end else begin
            k_n     = k_idx + CNT_W'(1);
            state_n = S_ISSUE;
          end
        end
      end
      S_WB: state_n = S_WB_WAIT;
      S_WB_WAIT: begin
        if (wb_done) begin
          if (n_idx == n_last) begin
            state_n = S_FIN;
          end else begin
            n_n     = n_idx + CNT_W'(1);
            k_n     = '0;
            state_n = S_ISSUE;
          end
        end
      end
      S_FIN:   state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_tile_scheduler.sv
// tb/tb_tile_scheduler.sv - self-checking bench for tile_scheduler
module tb_tile_scheduler;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             cfg_valid;
  logic [CNT_W-1:0] cfg_k_tiles;
  logic [CNT_W-1:0] cfg_n_tiles;
  logic             cfg_ready;
  logic             ctrl_start;
  logic             ctrl_ready;
  logic             acc_clr;
  logic             wb_start;
  logic             wb_done;
  logic [CNT_W-1:0] k_idx;
  logic [CNT_W-1:0] n_idx;
  logic             busy;
  logic             done;

  always #5 clk = ~clk;

  tile_scheduler #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_k_tiles(cfg_k_tiles),
    .cfg_n_tiles(cfg_n_tiles), .cfg_ready(cfg_ready), .ctrl_start(ctrl_start),
    .ctrl_ready(ctrl_ready), .acc_clr(acc_clr), .wb_start(wb_start),
    .wb_done(wb_done), .k_idx(k_idx), .n_idx(n_idx), .busy(busy), .done(done)
  );

  // Expected event stream: kind 0 = ctrl_start, 1 = wb_start, 2 = done.
  typedef struct {
    int   kind;
    int   k;
    int   n;
    logic clr;
  } ev_t;
  ev_t exp_q[$];

  typedef struct {
    int cfg_k;
    int cfg_n;
    int exp_starts;
    int exp_wbs;
    int exp_klast;
    int exp_nlast;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int starts_seen = 0, wbs_seen = 0, dones_seen = 0;
  int rise_cyc = 0;
  int accept_cyc = 0;
  bit chk_first = 0;
  int ack_lag = 1;
  int run_len = 5;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_layer(input int ck, input int cn);
    int ke = (ck == 0) ? 1 : ck;
    int ne = (cn == 0) ? 1 : cn;
    ev_t e;
    for (int ni = 0; ni < ne; ni++) begin
      for (int ki = 0; ki < ke; ki++) begin
        e.kind = 0; e.k = ki; e.n = ni; e.clr = (ki == 0);
        exp_q.push_back(e);
      end
      e.kind = 1; e.k = 0; e.n = 0; e.clr = 0;
      exp_q.push_back(e);
    end
    e.kind = 2; e.k = 0; e.n = 0; e.clr = 0;
    exp_q.push_back(e);
  endtask

  // Scoreboard: pop and compare on every observed pulse.
  always @(negedge clk) begin
    ev_t e;
    if (!rst) begin
      if (!ctrl_start) check("acc_clr_without_start", int'(acc_clr), 0);
      if (ctrl_start || wb_start || done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_event", int'({done, wb_start, ctrl_start}), 0);
        end else begin
          e = exp_q.pop_front();
          if (ctrl_start) begin
            starts_seen++;
            check("event_kind_start", 0, e.kind);
            check("start_k_idx", int'(k_idx), e.k);
            check("start_n_idx", int'(n_idx), e.n);
            check("start_acc_clr", int'(acc_clr), int'(e.clr));
            if (e.k != 0) check("tile_to_start_latency", cyc - rise_cyc, 2);
            if (chk_first && e.k == 0 && e.n == 0)
              check("accept_to_start_latency", cyc - accept_cyc, 2);
          end else if (wb_start) begin
            wbs_seen++;
            check("event_kind_wb", 1, e.kind);
          end else begin
            dones_seen++;
            check("event_kind_done", 2, e.kind);
          end
        end
      end
    end
  end

  // Array controller model: drop ready ack_lag cycles after start, raise after run_len.
  initial begin
    ctrl_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (ctrl_start && !rst) begin
        repeat (ack_lag) @(negedge clk);
        ctrl_ready = 1'b0;
        repeat (run_len) @(negedge clk);
        ctrl_ready = 1'b1;
        rise_cyc = cyc;
      end
    end
  end

  // Writeback engine model: wb_done 3 cycles after wb_start.
  initial begin
    wb_done = 1'b0;
    forever begin
      @(negedge clk);
      if (wb_start && !rst) begin
        repeat (3) @(negedge clk);
        wb_done = 1'b1;
        @(negedge clk);
        wb_done = 1'b0;
      end
    end
  end

  task automatic drive_cfg(input int ck, input int cn, input bit lat);
    @(negedge clk);
    check("cfg_ready_before_accept", int'(cfg_ready), 1);
    push_layer(ck, cn);
    cfg_k_tiles = CNT_W'(ck);
    cfg_n_tiles = CNT_W'(cn);
    cfg_valid   = 1'b1;
    accept_cyc  = cyc;
    chk_first   = lat;
    @(negedge clk);
    cfg_valid = 1'b0;
    check("busy_after_accept", int'(busy), 1);
  endtask

  task automatic wait_done(input int d0);
    int t = 0;
    while (dones_seen == d0 && t < 20000) begin
      @(negedge clk);
      t++;
    end
    check("done_within_budget", int'(dones_seen != d0), 1);
  endtask

  task automatic finish_layer(input string name, input int s0, input int w0, input int d0,
                              input int es, input int ew, input int kl, input int nl);
    wait_done(d0);
    @(negedge clk);
    check({name, "_starts"}, starts_seen - s0, es);
    check({name, "_wbs"}, wbs_seen - w0, ew);
    check({name, "_dones"}, dones_seen - d0, 1);
    check({name, "_queue_empty"}, exp_q.size(), 0);
    check({name, "_cfg_ready_after"}, int'(cfg_ready), 1);
    check({name, "_busy_after"}, int'(busy), 0);
    check({name, "_k_idx_hold"}, int'(k_idx), kl);
    check({name, "_n_idx_hold"}, int'(n_idx), nl);
  endtask

  vec_t vecs[6];

  initial begin
    int s0, w0, d0, t;
    vecs[0] = '{1, 1, 1, 1, 0, 0};
    vecs[1] = '{3, 2, 6, 2, 2, 1};
    vecs[2] = '{0, 0, 1, 1, 0, 0};
    vecs[3] = '{2, 1, 2, 1, 1, 0};
    vecs[4] = '{1, 3, 3, 3, 0, 2};
    vecs[5] = '{255, 1, 255, 1, 254, 0};

    rst = 1'b1; cfg_valid = 1'b0; cfg_k_tiles = '0; cfg_n_tiles = '0;
    repeat (3) @(negedge clk);
    check("rst_cfg_ready", int'(cfg_ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_ctrl_start", int'(ctrl_start), 0);
    check("rst_acc_clr", int'(acc_clr), 0);
    check("rst_wb_start", int'(wb_start), 0);
    check("rst_done", int'(done), 0);
    check("rst_k_idx", int'(k_idx), 0);
    check("rst_n_idx", int'(n_idx), 0);
    rst = 1'b0;

    // Table-driven layers.
    foreach (vecs[i]) begin
      s0 = starts_seen; w0 = wbs_seen; d0 = dones_seen;
      drive_cfg(vecs[i].cfg_k, vecs[i].cfg_n, 1'b1);
      finish_layer($sformatf("vec%0d", i), s0, w0, d0, vecs[i].exp_starts,
                   vecs[i].exp_wbs, vecs[i].exp_klast, vecs[i].exp_nlast);
    end

    // ctrl_ready held low in ISSUE: no start may be issued.
    s0 = starts_seen; w0 = wbs_seen; d0 = dones_seen;
    @(negedge clk);
    ctrl_ready = 1'b0;
    drive_cfg(1, 1, 1'b0);
    repeat (10) @(negedge clk);
    check("hold_low_no_start", starts_seen - s0, 0);
    check("hold_low_busy", int'(busy), 1);
    ctrl_ready = 1'b1;
    finish_layer("hold_low", s0, w0, d0, 1, 1, 0, 0);

    // Slow ack: ready stays high 4 cycles after start.
    ack_lag = 4;
    s0 = starts_seen; w0 = wbs_seen; d0 = dones_seen;
    drive_cfg(2, 1, 1'b1);
    finish_layer("slow_ack", s0, w0, d0, 2, 1, 1, 0);
    ack_lag = 1;

    // Config pulse and spurious wb_done while running are ignored.
    s0 = starts_seen; w0 = wbs_seen; d0 = dones_seen;
    drive_cfg(2, 2, 1'b1);
    t = 0;
    while (!ctrl_start && t < 100) begin @(negedge clk); t++; end
    check("ignore_first_start_seen", int'(ctrl_start), 1);
    repeat (2) @(negedge clk);
    cfg_k_tiles = CNT_W'(5); cfg_n_tiles = CNT_W'(5);
    cfg_valid = 1'b1; wb_done = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0; wb_done = 1'b0;
    finish_layer("ignore_busy", s0, w0, d0, 4, 2, 1, 1);

    // Reset in WB_WAIT, then a clean layer.
    drive_cfg(2, 3, 1'b1);
    t = 0;
    while (!wb_start && t < 200) begin @(negedge clk); t++; end
    check("rst_mid_wb_seen", int'(wb_start), 1);
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("midrst_cfg_ready", int'(cfg_ready), 1);
    check("midrst_busy", int'(busy), 0);
    check("midrst_ctrl_start", int'(ctrl_start), 0);
    check("midrst_wb_start", int'(wb_start), 0);
    check("midrst_done", int'(done), 0);
    check("midrst_k_idx", int'(k_idx), 0);
    check("midrst_n_idx", int'(n_idx), 0);
    rst = 1'b0;
    s0 = starts_seen; w0 = wbs_seen; d0 = dones_seen;
    drive_cfg(1, 1, 1'b1);
    finish_layer("after_rst", s0, w0, d0, 1, 1, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
